// File: rtl/hive_xsr_ctrl_pkg.sv
// Shared Hive parameters and the external-interrupt register map.
package hive_xsr_ctrl_pkg;

  localparam int THREADS     = 8;
  localparam int ID_W        = 3;
  localparam int ALU_W       = 32;
  localparam int RBUS_ADDR_W = 8;

  localparam logic [RBUS_ADDR_W-1:0] XSR_REG_BASE = 8'h20;
  localparam logic [2:0] XSR_EN_OFS   = 3'd0;
  localparam logic [2:0] XSR_MODE_OFS = 3'd1;
  localparam logic [2:0] XSR_PEND_OFS = 3'd2;
  localparam logic [2:0] XSR_SET_OFS  = 3'd3;
  localparam logic [2:0] XSR_ERR_OFS  = 3'd4;
  localparam int XSR_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    XSR_EN   = 3'd0,
    XSR_MODE = 3'd1,
    XSR_PEND = 3'd2,
    XSR_SET  = 3'd3,
    XSR_ERR  = 3'd4,
    XSR_NONE = 3'd7
  } xsr_reg_e;

  // Map an rbus address onto one of the five registers, or none.
  function automatic xsr_reg_e xsr_decode(input logic [RBUS_ADDR_W-1:0] addr,
                                          input logic [RBUS_ADDR_W-1:0] base);
    logic [RBUS_ADDR_W-1:0] ofs;
    ofs = addr - base;
    case (ofs)
      RBUS_ADDR_W'(XSR_EN_OFS):   return XSR_EN;
      RBUS_ADDR_W'(XSR_MODE_OFS): return XSR_MODE;
      RBUS_ADDR_W'(XSR_PEND_OFS): return XSR_PEND;
      RBUS_ADDR_W'(XSR_SET_OFS):  return XSR_SET;
      RBUS_ADDR_W'(XSR_ERR_OFS):  return XSR_ERR;
      default:                    return XSR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hive_xsr_ctrl_if.sv
// rbus register-access bundle; master drives the strobes, slave returns read data.
interface hive_xsr_ctrl_if;
  import hive_xsr_ctrl_pkg::*;

  logic [RBUS_ADDR_W-1:0] rbus_addr_i;
  logic                   rbus_wr_i;
  logic                   rbus_rd_i;
  logic [ALU_W-1:0]       rbus_wr_data_i;
  logic [ALU_W-1:0]       rbus_rd_data_o;

  modport master (output rbus_addr_i, rbus_wr_i, rbus_rd_i, rbus_wr_data_i,
                  input  rbus_rd_data_o);
  modport slave  (input  rbus_addr_i, rbus_wr_i, rbus_rd_i, rbus_wr_data_i,
                  output rbus_rd_data_o);
endinterface

// File: rtl/hive_xsr_ctrl_sync_vec.sv
// Multi-bit flop-chain synchronizer with synchronous reset; each bit is independent.
module hive_sync_vec #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sync_q;

  // Shift the raw input through DEPTH flops; stage 0 is the metastable one.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[DEPTH-2:0], d_i};
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/hive_xsr_ctrl.sv
// External-interrupt front end: sync, edge/level pending, enable gating, rbus regs.
module hive_xsr_ctrl
  import hive_xsr_ctrl_pkg::*;
#(
  parameter int                     SYNC_STAGES = XSR_SYNC_STAGES,
  parameter logic [RBUS_ADDR_W-1:0] REG_BASE    = XSR_REG_BASE
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [THREADS-1:0] src_i,
  input  logic [ID_W-1:0]    id_i,
  input  logic               irq_i,
  input  logic [THREADS-1:0] irq_er_i,
  output logic [THREADS-1:0] xsr_o,
  hive_xsr_ctrl_if.slave     rbus
);

  logic [THREADS-1:0] s, s_d_q;
  logic [THREADS-1:0] en_q, en_d, mode_q, mode_d, pend_q, pend_d;
  logic [THREADS-1:0] err_q, err_d, xsr_q, xsr_d;
  logic [THREADS-1:0] wd, rise, irq_hit, mode_chg;
  logic [THREADS-1:0] set_w, clr_w, err_w;
  logic               we_en, we_mode;
  logic [ALU_W-1:0]   rd_q, rd_d;
  xsr_reg_e           sel;

  hive_sync_vec #(.WIDTH(THREADS), .DEPTH(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (src_i),
    .q_o   (s)
  );

  assign sel  = xsr_decode(rbus.rbus_addr_i, REG_BASE);
  assign wd   = rbus.rbus_wr_data_i[THREADS-1:0];
  assign rise = s & ~s_d_q;

  generate
    if (THREADS < ALU_W) begin : g_wd_hi
      logic unused_wd_hi;
      assign unused_wd_hi = ^rbus.rbus_wr_data_i[ALU_W-1:THREADS];
    end
    for (genvar t = 0; t < THREADS; t++) begin : g_hit
      assign irq_hit[t] = irq_i && (id_i == ID_W'(t));
    end
  endgenerate

  // Decode rbus writes into per-register bit masks.
  always_comb begin
    we_en   = rbus.rbus_wr_i && (sel == XSR_EN);
    we_mode = rbus.rbus_wr_i && (sel == XSR_MODE);
    clr_w   = (rbus.rbus_wr_i && (sel == XSR_PEND)) ? wd : '0;
    set_w   = (rbus.rbus_wr_i && (sel == XSR_SET))  ? wd : '0;
    err_w   = (rbus.rbus_wr_i && (sel == XSR_ERR))  ? wd : '0;
  end

  // Next state for enable, mode, pending and sticky error bits.
  always_comb begin
    en_d     = we_en   ? wd : en_q;
    mode_d   = we_mode ? wd : mode_q;
    mode_chg = we_mode ? (wd ^ mode_q) : '0;
    pend_d   = pend_q;
    for (int t = 0; t < THREADS; t++) begin
      if (mode_chg[t])                   pend_d[t] = 1'b0;
      else if (!mode_q[t])               pend_d[t] = s[t];
      else if (rise[t] || set_w[t])      pend_d[t] = 1'b1;  // set beats clear
      else if (irq_hit[t] || clr_w[t])   pend_d[t] = 1'b0;
    end
    // A fresh error beats a same-cycle W1C.
    err_d = (err_q & ~err_w) | irq_er_i;
    // Registered from next-state so xsr_o tracks pend & en with no extra cycle.
    xsr_d = pend_d & en_d;
  end

  // Readback mux: pre-write register values, zero when not addressed.
  always_comb begin
    rd_d = '0;
    if (rbus.rbus_rd_i) begin
      case (sel)
        XSR_EN:   rd_d[THREADS-1:0] = en_q;
        XSR_MODE: rd_d[THREADS-1:0] = mode_q;
        XSR_PEND: rd_d[THREADS-1:0] = pend_q;
        XSR_ERR:  rd_d[THREADS-1:0] = err_q;
        default:  rd_d = '0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_d_q  <= '0;
      en_q   <= '0;
      mode_q <= '0;
      pend_q <= '0;
      err_q  <= '0;
      xsr_q  <= '0;
      rd_q   <= '0;
    end else begin
      s_d_q  <= s;
      en_q   <= en_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      xsr_q  <= xsr_d;
      rd_q   <= rd_d;
    end
  end

  assign xsr_o               = xsr_q;
  assign rbus.rbus_rd_data_o = rd_q;

endmodule

// File: tb/tb_hive_xsr_ctrl.sv
// Directed plan plus randomized traffic, checked against a cycle model of the register rules.
module tb_hive_xsr_ctrl;
  import hive_xsr_ctrl_pkg::*;

  localparam int SYNC = 2;
  localparam logic [7:0] B = 8'h20;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [7:0] src_i = '0;
  logic [2:0] id_i = '0;
  logic irq_i = 1'b0;
  logic [7:0] irq_er_i = '0;
  logic [7:0] xsr_o;

  hive_xsr_ctrl_if rbus ();

  hive_xsr_ctrl #(.SYNC_STAGES(SYNC), .REG_BASE(B)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .src_i    (src_i),
    .id_i     (id_i),
    .irq_i    (irq_i),
    .irq_er_i (irq_er_i),
    .xsr_o    (xsr_o),
    .rbus     (rbus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each negedge: check last edge's outputs, then apply the rules to this cycle's inputs.
  logic [7:0]  m_en, m_mode, m_pend, m_err, exp_xsr;
  logic [31:0] exp_rd;
  logic [7:0]  hist[$];
  bit          m_valid = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("model_xsr", {24'h0, xsr_o}, {24'h0, exp_xsr});
        chk("model_rd", rbus.rbus_rd_data_o, exp_rd);
      end
      if (rst_i) begin
        m_en = 0; m_mode = 0; m_pend = 0; m_err = 0; exp_xsr = 0; exp_rd = 0;
        hist = {};
        for (int i = 0; i <= SYNC; i++) hist.push_back(8'h0);
        m_valid = 1;
      end else if (m_valid) begin
        logic [7:0] s, sd, wd, np, ne, nm;
        int ofs;
        bit hit;
        s  = hist[hist.size() - SYNC];        // src seen SYNC cycles ago
        sd = hist[hist.size() - SYNC - 1];
        wd = rbus.rbus_wr_data_i[7:0];
        ofs = int'(rbus.rbus_addr_i) - int'(B);
        hit = (ofs >= 0) && (ofs <= 4);
        exp_rd = 0;
        if (rbus.rbus_rd_i && hit) begin
          case (ofs)
            0: exp_rd = {24'h0, m_en};
            1: exp_rd = {24'h0, m_mode};
            2: exp_rd = {24'h0, m_pend};
            4: exp_rd = {24'h0, m_err};
            default: exp_rd = 0;
          endcase
        end
        np = m_pend; ne = m_en; nm = m_mode;
        for (int t = 0; t < 8; t++) begin
          bit wr_mode_chg, setb, clrb;
          wr_mode_chg = rbus.rbus_wr_i && hit && ofs == 1 && (wd[t] != m_mode[t]);
          setb = (s[t] && !sd[t]) || (rbus.rbus_wr_i && hit && ofs == 3 && wd[t]);
          clrb = (irq_i && int'(id_i) == t) || (rbus.rbus_wr_i && hit && ofs == 2 && wd[t]);
          if (wr_mode_chg)     np[t] = 0;
          else if (!m_mode[t]) np[t] = s[t];
          else if (setb)       np[t] = 1;
          else if (clrb)       np[t] = 0;
        end
        if (rbus.rbus_wr_i && hit && ofs == 0) ne = wd;
        if (rbus.rbus_wr_i && hit && ofs == 1) nm = wd;
        if (rbus.rbus_wr_i && hit && ofs == 4) m_err = m_err & ~wd;
        m_err  = m_err | irq_er_i;
        m_pend = np; m_en = ne; m_mode = nm;
        exp_xsr = np & ne;
        hist.push_back(src_i);
        if (hist.size() > SYNC + 2) void'(hist.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    rbus.rbus_addr_i = a; rbus.rbus_wr_data_i = d; rbus.rbus_wr_i = 1'b1;
    tick();
    rbus.rbus_wr_i = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
    rbus.rbus_addr_i = a; rbus.rbus_rd_i = 1'b1;
    tick();
    rbus.rbus_rd_i = 1'b0;
    chk(nm, rbus.rbus_rd_data_o, exp);
  endtask

  initial begin
    rbus.rbus_addr_i = '0; rbus.rbus_wr_i = 0; rbus.rbus_rd_i = 0; rbus.rbus_wr_data_i = '0;
    tick(); tick();
    chk("reset_xsr", {24'h0, xsr_o}, 32'h0);
    chk("reset_rd", rbus.rbus_rd_data_o, 32'h0);
    rst_i = 0;

    // edge-mode pulse on thread 2
    wr(B + 0, 32'h0F); wr(B + 1, 32'hFF);
    src_i = 8'h04; tick(); src_i = 0;
    tick(); chk("edge_lat2", {24'h0, xsr_o}, 32'h00);
    tick(); chk("edge_lat3", {24'h0, xsr_o}, 32'h04);
    tick(); chk("edge_hold", {24'h0, xsr_o}, 32'h04);

    // irq clears; then edge coincides with irq
    irq_i = 1; id_i = 3'd2; tick(); irq_i = 0;
    chk("irq_clear", {24'h0, xsr_o}, 32'h00);
    src_i = 8'h04; tick(); src_i = 0; tick();
    irq_i = 1; id_i = 3'd2; tick(); irq_i = 0;
    chk("set_beats_irq", {24'h0, xsr_o}, 32'h04);

    // level mode on thread 5
    wr(B + 1, 32'h00); wr(B + 0, 32'h20);
    src_i = 8'h20; tick(); tick();
    chk("lvl_rise2", {24'h0, xsr_o}, 32'h00);
    tick(); chk("lvl_rise3", {24'h0, xsr_o}, 32'h20);
    wr(B + 2, 32'h20); chk("lvl_w1c_a", {24'h0, xsr_o}, 32'h20);
    tick(); chk("lvl_w1c_b", {24'h0, xsr_o}, 32'h20);
    src_i = 0; tick(); tick();
    chk("lvl_fall2", {24'h0, xsr_o}, 32'h20);
    tick(); chk("lvl_fall3", {24'h0, xsr_o}, 32'h00);

    // edge latched while disabled
    wr(B + 1, 32'h02); wr(B + 0, 32'h00);
    src_i = 8'h02; tick(); src_i = 0; tick(); tick(); tick();
    chk("masked", {24'h0, xsr_o}, 32'h00);
    wr(B + 0, 32'h02); chk("en_open", {24'h0, xsr_o}, 32'h02);
    rd("rd_pend", B + 2, 32'h02);
    tick(); chk("rd_one_cycle", rbus.rbus_rd_data_o, 32'h0);

    // software set, error flags
    wr(B + 1, 32'h82); wr(B + 0, 32'h80);
    chk("pre_set", {24'h0, xsr_o}, 32'h00);
    wr(B + 3, 32'h80); chk("sw_set", {24'h0, xsr_o}, 32'h80);
    irq_er_i = 8'h80; tick(); irq_er_i = 0;
    rd("rd_err", B + 4, 32'h80);
    wr(B + 4, 32'h80);
    rd("rd_err_clr", B + 4, 32'h00);

    // mid-operation reset with pend=0x84
    wr(B + 1, 32'h86); wr(B + 3, 32'h04); wr(B + 2, 32'h02);
    rd("rd_pend84", B + 2, 32'h84);
    wr(B + 0, 32'hFF); chk("xsr84", {24'h0, xsr_o}, 32'h84);
    rbus.rbus_addr_i = B + 2; rbus.rbus_rd_i = 1; rst_i = 1;
    tick(); rst_i = 0; rbus.rbus_rd_i = 0;
    chk("mid_rst_xsr", {24'h0, xsr_o}, 32'h00);
    chk("mid_rst_rd", rbus.rbus_rd_data_o, 32'h0);
    rd("rst_en", B + 0, 0); rd("rst_mode", B + 1, 0);
    rd("rst_pend", B + 2, 0); rd("rst_err", B + 4, 0);
    wr(B + 0, 32'h5A);
    rd("rd_miss_hi", B + 5, 0); rd("rd_miss_lo", B - 1, 0);
    rd("rd_set", B + 3, 0); rd("rd_en", B + 0, 32'h5A);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      src_i = src_i ^ (8'($urandom) & 8'($urandom));
      irq_i = ($urandom_range(0, 2) == 0);
      id_i  = 3'($urandom);
      irq_er_i = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
      rbus.rbus_addr_i = B - 8'd2 + 8'($urandom_range(0, 8));
      rbus.rbus_wr_i = ($urandom_range(0, 2) == 0);
      rbus.rbus_rd_i = ($urandom_range(0, 1) == 0);
      rbus.rbus_wr_data_i = $urandom;
      tick();
    end
    rst_i = 0; rbus.rbus_wr_i = 0; rbus.rbus_rd_i = 0; irq_i = 0; irq_er_i = 0;
    tick(); tick();
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hive_xsr_ctrl.md
# hive_xsr_ctrl

External-interrupt front end for the Hive core, directly upstream of the control ring's `xsr_i` input. It synchronizes per-thread external interrupt sources and latches edge events into per-thread pending bits. Pending bits are gated by an enable mask and presented as `xsr_o`. Pending bits clear when the control ring reports the interrupt taken for that thread, and irq-while-in-service errors are recorded. All registers are exposed on the rbus.

## Interface
Parameters:
- SYNC_STAGES, default 2: synchronizer depth on `src_i`, minimum 2.
- REG_BASE, default 'h20: rbus base address. Uses five consecutive addresses, REG_BASE+0 through +4.
- THREADS, ID_W, ALU_W, RBUS_ADDR_W: taken from hive_params. THREADS ≤ ALU_W.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- src_i  in  THREADS  raw external interrupt sources, asynchronous, one per thread.
- id_i  in  ID_W  thread ID accompanying `irq_i`.
- irq_i  in  1  control ring reports an interrupt taken for thread `id_i`.
- irq_er_i  in  THREADS  irq-while-in-service flags from the control ring.
- xsr_o  out  THREADS  interrupt requests, equal to `pend & en`; connects to the control ring's `xsr_i`.
- rbus_addr_i  in  RBUS_ADDR_W  rbus address.
- rbus_wr_i  in  1  rbus write strobe.
- rbus_rd_i  in  1  rbus read strobe.
- rbus_wr_data_i  in  ALU_W  rbus write data.
- rbus_rd_data_o  out  ALU_W  rbus read data; zero when not selected, so it can be ORed with other rbus readers.

## Operation
- Synchronizer: SYNC_STAGES flops per bit produce `s`. `s_d` is `s` delayed one cycle.
- Register map, offsets from REG_BASE. Bits above THREADS read 0 and ignore writes.
  - +0 EN, rw: request enable mask.
  - +1 MODE, rw: per thread, 1 = edge mode, 0 = level mode.
  - +2 PEND: read returns pending bits. Writing 1 clears the edge-mode bit.
  - +3 SET: write 1 sets the edge-mode pending bit (software interrupt). Reads 0.
  - +4 ERR: read returns sticky error bits. Writing 1 clears.
- Level-mode thread t: `pend[t]` follows `s[t]` each cycle. PEND W1C, SET writes, and `irq_i` have no effect on it.
- Edge-mode thread t, next-state priority:
  - set: rising edge (`s & ~s_d`), or a SET write bit.
  - otherwise clear: `irq_i && id_i==t`, or a PEND W1C bit.
  - set wins over clear in the same cycle, so no edge is lost.
- Edges latch regardless of EN. EN gates only `xsr_o`.
- A MODE write clears `pend` for every thread whose mode bit changes.
- ERR[t] sets on `irq_er_i[t]`. In the same cycle, a W1C on ERR loses to a new error.
- Reset: EN, MODE, PEND, ERR, the synchronizer flops, `s_d`, `xsr_o` and `rbus_rd_data_o` all go to 0. Mid-operation reset discards pending events.

## Timing
- `xsr_o` is registered (equal to `pend & en` after the clock edge).
- `src_i` rise → `xsr_o` rise: SYNC_STAGES+1 cycles (3 cycles by default).
- Level-mode fall follows with the same latency.
- `irq_i` at cycle n → `xsr_o[t]` low at n+1, unless a new edge arrives.
- rbus write at cycle n: register updated at n+1; `xsr_o` reflects an EN change at n+1.
- rbus read: `rbus_rd_i` at n with a matching address → `rbus_rd_data_o` valid at n+1 only, otherwise 0.
- Read and write in the same cycle to the same register: the read returns the pre-write value.

## Structure
- hive_params gets XSR_REG_BASE, XSR_EN_OFS … XSR_ERR_OFS and XSR_SYNC_STAGES.
- One sub-module: `hive_sync_vec`, a parameterized multi-bit synchronizer with width and depth parameters and synchronous reset. It is reusable for other external inputs.
- The top level holds the register file, edge detect, pending logic and the rbus decode/readback register.

## Test plan
THREADS=8, SYNC_STAGES=2.
- Reset, then EN=0x0F, MODE=0xFF, pulse `src_i[2]` for 1 cycle → `xsr_o`=0x04 exactly 3 cycles after the pulse, and it stays high.
- From that state, `irq_i`=1 with `id_i`=2 → `xsr_o`=0x00 next cycle. Repeat with a new `src_i[2]` edge landing in the same cycle as `irq_i` → `xsr_o` stays 0x04.
- MODE=0x00, hold `src_i[5]`=1 with EN=0x20 → `xsr_o[5]` high after 3 cycles and low 3 cycles after the source falls. PEND W1C 0x20 while the source is held has no effect.
- EN=0x00, edge on `src_i[1]` → `xsr_o`=0. Then write EN=0x02 → `xsr_o`=0x02 the next cycle. Read PEND → `rbus_rd_data_o`=0x02 one cycle after the read, and 0 on the following cycle.
- SET write 0x80 with MODE[7]=1 and EN=0x80 → `xsr_o`=0x80. Pulse `irq_er_i[7]` → ERR reads 0x80. ERR W1C 0x80 → reads 0.
- Assert `rst_i` mid-operation with pending 0x84 → all outputs and registers 0 the following cycle. Reads of a non-matching address → 0.
